any1_agen_pipe: RTL and testbench
=================================

# any1_agen_pipe

Pipelined, parametrised effective-address generator for the ANY-1 memory stage. It sits between register read and the data-cache/TLB request port, with a valid/ready handshake on both sides. It supports three addressing modes, a configurable address width, and an optional post-update writeback value. Every result carries alignment, bounds and canonical-address fault flags.

## Interface
Parameters:
- AWID, 32, effective-address width in bits (16..64)
- ALIGN_CHK, 1, 1 = raise alignment fault on misaligned access; 0 = never
- BOUND_CHK, 1, 1 = compare against lim_lo/lim_hi; 0 = never fault

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  request present
- i_ready  out  1  block can accept request this cycle
- ir  in  64  instruction; Sc=ir[43:41], mode=ir[45:44], disp={{42{ir[63]}},ir[63:50],ir[39:32]}
- ia  in  64  base register
- ib  in  64  index register
- size  in  2  access size, bytes = 1<<size (1,2,4,8)
- lim_lo, lim_hi  in  AWID  inclusive segment bounds
- o_valid  out  1  result present
- o_ready  in  1  consumer accepts result
- ea  out  AWID  effective address
- wb  out  64  post-update value (ia+disp), meaningful when wb_en
- wb_en  out  1  mode 10 request
- flt_align, flt_bound, flt_canon, flt_mode  out  1 each  fault flags

## Operation
- Address arithmetic is full 64-bit, two's complement, wrapping mod 2^64:
  - mode 00: sum = ia + disp
  - mode 01: sum = ia + (ib << Sc) + disp. The shift applies to ib only, not to the sum.
  - mode 10: sum = ia + disp; wb = ia + disp; wb_en = 1.
  - mode 11: reserved. flt_mode = 1, sum computed as mode 00.
- ea = sum[AWID-1:0].
- flt_canon = 1 when AWID<64 and sum[63:AWID] is not all equal to sum[AWID-1]. It is always 0 when AWID=64.
- flt_align = ALIGN_CHK & ((ea & ((1<<size)-1)) != 0).
- flt_bound = BOUND_CHK & ((ea < lim_lo) | (ea + (1<<size) - 1 > lim_hi)).
  - The upper compare is done at AWID+1 bits, so a last byte that wraps past 2^AWID faults.
  - Comparisons are unsigned.
- Faults do not suppress the result. The transaction still completes with the flags set.
- Pipeline has two register stages:
  - S1 latches the sum, the operand copies needed by the checks, size and mode.
  - S2 latches ea, wb, wb_en and all flags.
- Each stage has a valid bit. A stage loads when it is empty or when its content moves to the next stage in the same cycle.
  - i_ready = !s1_v | (!s2_v | o_ready).
  - S2 advances when !s2_v | o_ready.
- Reset clears s1_v and s2_v. Reset values of the outputs: o_valid=0, ea=0, wb=0, wb_en=0, all flags 0. i_ready is 1 in the cycle after reset.
- rst asserted mid-flight discards all in-flight requests; no output is produced for them.

## Timing
- Latency: a request accepted in cycle N (i_valid & i_ready) has o_valid=1 in cycle N+2 when there is no backpressure.
- Throughput is one request per cycle while o_ready=1.
- While o_valid=1 and o_ready=0, ea, wb, wb_en and the flags hold stable. S1 may still fill once; i_ready then drops to 0 with both stages full.
- When both stages are full and o_ready rises, in that same cycle:
  - S2 takes S1's content,
  - S1 accepts a new request,
  - i_ready is 1.
  No bubble is inserted.
- i_ready depends combinationally on o_ready. o_valid and all data outputs come directly from registers.
- Inputs are sampled only on the accept edge. ir, ia and ib may change freely otherwise.

## Test plan
- Mode 01, no faults: ia=0x1000, ib=0x10, Sc=3, disp=8, size=3, lim 0..0xFFFF -> two cycles later ea=0x1088, all flags 0.
- Negative disp with wrap: ir[63:50] all 1, ir[39:32]=0xFF (disp=-1), ia=0, mode 00, AWID=32 -> ea=0xFFFFFFFF, flt_canon=0. Then ia=0x1_0000_0000 -> flt_canon=1.
- Post-update and reserved mode:
  - mode 10, ia=0x200, disp=0x20 -> ea=0x220, wb=0x220, wb_en=1.
  - mode 11 -> flt_mode=1.
- Alignment and bounds:
  - size=2, ea=0x1002 -> flt_align=1.
  - lim_hi=0x1003, ea=0x1000, size=3 -> flt_bound=1.
  - lim_hi=0x1007, same ea and size -> flt_bound=0.
- Backpressure:
  - Stream 6 back-to-back requests; hold o_ready=0 for 4 cycles mid-stream. Outputs must stay stable and i_ready must drop once both stages are full.
  - Release o_ready. All 6 results must emerge in order, none lost or duplicated.
- Reset mid-flight: assert rst for one cycle with both stages full. Next cycle o_valid=0 and i_ready=1, and the old requests never appear.

Source files
------------

// File: rtl/any1_agen_pipe.sv
// ANY-1 memory-stage effective-address generator: two register stages with
// valid/ready on both sides, producing an address, post-update value and fault flags.
module any1_agen_pipe #(
  parameter int AWID      = 32,
  parameter int ALIGN_CHK = 1,
  parameter int BOUND_CHK = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [63:0]     ir,
  input  logic [63:0]     ia,
  input  logic [63:0]     ib,
  input  logic [1:0]      size,
  input  logic [AWID-1:0] lim_lo,
  input  logic [AWID-1:0] lim_hi,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [AWID-1:0] ea,
  output logic [63:0]     wb,
  output logic            wb_en,
  output logic            flt_align,
  output logic            flt_bound,
  output logic            flt_canon,
  output logic            flt_mode
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // A stage loads when empty or when its content moves on in the same cycle.
  logic s1_v, s2_v, s2_adv, s1_load;

  assign s2_adv  = !s2_v || o_ready;
  assign i_ready = !s1_v || s2_adv;
  assign s1_load = i_valid && i_ready;
  assign o_valid = s2_v;

  // Request decode and full 64-bit wrapping address arithmetic.
  logic [63:0] disp, idx, sum_c, wb_c;
  logic        unused_ir;

  assign disp      = {{42{ir[63]}}, ir[63:50], ir[39:32]};
  assign idx       = (ir[45:44] == 2'b01) ? (ib << ir[43:41]) : 64'd0;
  assign sum_c     = ia + idx + disp;
  assign wb_c      = ia + disp;
  assign unused_ir = ^{ir[49:46], ir[40], ir[31:0]};

  logic [63:0]     s1_sum, s1_wb;
  logic [1:0]      s1_size, s1_mode;
  logic [AWID-1:0] s1_lo, s1_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (i_ready) begin
      s1_v <= i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sum  <= sum_c;
      s1_wb   <= wb_c;
      s1_size <= size;
      s1_mode <= ir[45:44];
      s1_lo   <= lim_lo;
      s1_hi   <= lim_hi;
    end
  end

  // Fault checks on the S1 contents.
  logic [AWID-1:0] ea_c;
  logic [3:0]      nbytes, amask;
  logic [AWID:0]   last_c;
  logic            align_c, bound_c, canon_c;

  assign ea_c   = s1_sum[AWID-1:0];
  assign nbytes = 4'd1 << s1_size;
  assign amask  = nbytes - 4'd1;
  // Last byte address at AWID+1 bits so an access straddling 2^AWID is caught.
  assign last_c = {1'b0, ea_c} + {{(AWID-3){1'b0}}, amask};

  assign align_c = (ALIGN_CHK != 0) && ((ea_c[3:0] & amask) != 4'd0);
  assign bound_c = (BOUND_CHK != 0) &&
                   ((ea_c < s1_lo) || (last_c > {1'b0, s1_hi}));

  generate
    if (AWID < 64) begin : g_canon
      assign canon_c = (s1_sum[63:AWID] != {(64-AWID){s1_sum[AWID-1]}});
    end else begin : g_nocanon
      assign canon_c = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v      <= 1'b0;
      ea        <= '0;
      wb        <= 64'd0;
      wb_en     <= 1'b0;
      flt_align <= 1'b0;
      flt_bound <= 1'b0;
      flt_canon <= 1'b0;
      flt_mode  <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        ea        <= ea_c;
        wb        <= s1_wb;
        wb_en     <= (s1_mode == 2'b10);
        flt_align <= align_c;
        flt_bound <= bound_c;
        flt_canon <= canon_c;
        flt_mode  <= (s1_mode == 2'b11);
      end
    end
  end

endmodule

// File: tb/tb_any1_agen_pipe.sv
// Bench for any1_agen_pipe: directed literal cases, backpressure, mid-flight reset
// and randomized traffic checked against a queue-based reference model.
module tb_any1_agen_pipe;
  localparam int AWID = 32;
  localparam int W    = AWID + 69;   // {ea, wb, wb_en, align, bound, canon, mode}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            i_valid, i_ready, o_valid, o_ready;
  logic [63:0]     ir, ia, ib, wb;
  logic [1:0]      size;
  logic [AWID-1:0] lim_lo, lim_hi, ea;
  logic            wb_en, flt_align, flt_bound, flt_canon, flt_mode;

  any1_agen_pipe #(.AWID(AWID), .ALIGN_CHK(1), .BOUND_CHK(1)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .ir(ir), .ia(ia), .ib(ib), .size(size),
    .lim_lo(lim_lo), .lim_hi(lim_hi),
    .o_valid(o_valid), .o_ready(o_ready),
    .ea(ea), .wb(wb), .wb_en(wb_en),
    .flt_align(flt_align), .flt_bound(flt_bound),
    .flt_canon(flt_canon), .flt_mode(flt_mode)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_ordy = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [63:0] r, input logic [63:0] a,
                                         input logic [63:0] b, input logic [1:0] s,
                                         input logic [AWID-1:0] lo, input logic [AWID-1:0] hi);
    logic [21:0]     dfield;
    logic [63:0]     dsp, sum, sx;
    logic [1:0]      md;
    logic [AWID-1:0] e;
    int unsigned     nb;
    logic [64:0]     last;
    logic            fa, fb, fc, fm;
    dfield = {r[63:50], r[39:32]};
    dsp    = 64'($signed(dfield));
    md     = r[45:44];
    sum    = a + dsp + ((md == 2'b01) ? (b << r[43:41]) : 64'd0);
    e      = sum[AWID-1:0];
    sx     = 64'($signed(e));
    nb     = 1 << s;
    last   = 65'(e) + 65'(nb) - 65'd1;
    fa     = (e % nb) != 0;
    fb     = (e < lo) || (last > 65'(hi));
    fc     = (sx != sum);
    fm     = (md == 2'b11);
    return {e, a + dsp, md == 2'b10, fa, fb, fc, fm};
  endfunction

  function automatic logic [63:0] mk_ir(input logic [1:0] m, input logic [2:0] sc,
                                        input logic [21:0] d);
    return {d[21:8], 4'b0, m, sc, 1'b0, d[7:0], 32'h0};
  endfunction

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (o_valid && o_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (i_valid && i_ready) exp_q.push_back(model(ir, ia, ib, size, lim_lo, lim_hi));
    end
  end

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got output ea=%0h with nothing outstanding", ea);
      end else begin
        check("sb_main", {ea, wb_en, flt_align, flt_bound, flt_canon, flt_mode},
              {exp_q[0][W-1 -: AWID], exp_q[0][4:0]});
        if (exp_q[0][4]) check("sb_wb", wb, exp_q[0][68:5]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ordy) o_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [63:0] r, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] s, input logic [AWID-1:0] lo, input logic [AWID-1:0] hi);
    bit done;
    done = 1'b0;
    ir = r; ia = a; ib = b; size = s; lim_lo = lo; lim_hi = hi;
    i_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = i_ready;
      tick();
    end
    i_valid = 1'b0;
    ir = {$urandom, $urandom};
    ia = {$urandom, $urandom};
    ib = {$urandom, $urandom};
    if (!done) fail_now("send_timeout");
  endtask

  // One request through an idle pipe, checked against hand-computed values.
  task automatic lit(input string nm, input logic [63:0] r, input logic [63:0] a,
                     input logic [63:0] b, input logic [1:0] s,
                     input logic [AWID-1:0] lo, input logic [AWID-1:0] hi,
                     input logic [AWID-1:0] x_ea, input logic [63:0] x_wb,
                     input logic x_wbe, input logic [3:0] x_flt);
    send(r, a, b, s, lo, hi);
    @(negedge clk);
    check({nm, "_early"}, o_valid, 1'b0);
    @(negedge clk);
    check({nm, "_valid"}, o_valid, 1'b1);
    check({nm, "_ea_flags"}, {ea, wb_en, flt_align, flt_bound, flt_canon, flt_mode},
          {x_ea, x_wbe, x_flt});
    if (x_wbe) check({nm, "_wb"}, wb, x_wb);
    tick();
  endtask

  task automatic rand_req();
    logic [63:0] a, b;
    logic [AWID-1:0] lo, hi;
    case ($urandom_range(0, 3))
      0, 1: a = 64'($urandom_range(0, 'h1FFFF));
      2:    a = {$urandom, $urandom};
      default: a = {31'h0, 1'($urandom), 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))};
    endcase
    b  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 'hFFF)) : {$urandom, $urandom};
    lo = AWID'($urandom_range(0, 'h3000));
    hi = ($urandom_range(0, 3) == 0) ? {AWID{1'b1}} : AWID'($urandom_range('h1000, 'h1FFFF));
    send(mk_ir(2'($urandom), 3'($urandom), 22'($urandom)), a, b, 2'($urandom), lo, hi);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    ir = '0; ia = '0; ib = '0; size = '0; lim_lo = '0; lim_hi = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ovalid", o_valid, 1'b0);
    check("rst_iready", i_ready, 1'b1);
    check("rst_outs", {ea, wb, wb_en, flt_align, flt_bound, flt_canon, flt_mode}, '0);
    tick();

    lit("m01",      mk_ir(2'd1, 3'd3, 22'd8),  64'h1000, 64'h10, 2'd3, 0, 32'hFFFF, 32'h1088, 0, 0, 4'b0000);
    lit("m01_sh7",  mk_ir(2'd1, 3'd7, 22'd0),  64'h0,    64'h1,  2'd0, 0, 32'hFFFF, 32'h80,   0, 0, 4'b0000);
    lit("neg_wrap", mk_ir(2'd0, 3'd0, -22'sd1), 64'h0,   64'h0,  2'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'b0000);
    lit("canon",    mk_ir(2'd0, 3'd0, -22'sd1), 64'h1_0000_0000, 64'h0, 2'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'b0010);
    lit("postupd",  mk_ir(2'd2, 3'd0, 22'h20), 64'h200, 64'h0, 2'd0, 0, 32'hFFFF, 32'h220, 64'h220, 1, 4'b0000);
    lit("rsvd",     mk_ir(2'd3, 3'd2, 22'd0),  64'h300, 64'h10, 2'd0, 0, 32'hFFFF, 32'h300, 0, 0, 4'b0001);
    lit("align",    mk_ir(2'd0, 3'd0, 22'd0),  64'h1002, 64'h0, 2'd2, 0, 32'hFFFF, 32'h1002, 0, 0, 4'b1000);
    lit("bnd_hi",   mk_ir(2'd0, 3'd0, 22'd0),  64'h1000, 64'h0, 2'd3, 0, 32'h1003, 32'h1000, 0, 0, 4'b0100);
    lit("bnd_ok",   mk_ir(2'd0, 3'd0, 22'd0),  64'h1000, 64'h0, 2'd3, 0, 32'h1007, 32'h1000, 0, 0, 4'b0000);
    lit("bnd_lo",   mk_ir(2'd0, 3'd0, 22'd0),  64'h0FFF, 64'h0, 2'd0, 32'h1000, 32'hFFFF, 32'h0FFF, 0, 0, 4'b0100);
    lit("bnd_wrap", mk_ir(2'd0, 3'd0, -22'sd4), 64'h0,   64'h0, 2'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 0, 4'b1100);

    // Six back-to-back requests with a 4-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(mk_ir(2'd1, 3'(i), 22'(i * 16)), 64'h4000 + 64'(i * 8), 64'(i), 2'd0, 0, 32'hFFFF);
      end
      begin
        @(posedge clk);
        #1 o_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_iready_low", i_ready, 1'b0);
        check("bp_ovalid_held", o_valid, 1'b1);
        @(posedge clk);
        #1 o_ready = 1'b1;
        @(negedge clk);
        check("bp_iready_release", i_ready, 1'b1);
      end
    join
    idle(6);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full.
    o_ready = 1'b0;
    send(mk_ir(2'd0, 3'd0, 22'h10), 64'h5000, 64'h0, 2'd0, 0, 32'hFFFF);
    send(mk_ir(2'd0, 3'd0, 22'h20), 64'h5000, 64'h0, 2'd0, 0, 32'hFFFF);
    @(negedge clk);
    check("full_ovalid", o_valid, 1'b1);
    check("full_iready", i_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ovalid", o_valid, 1'b0);
    check("mid_rst_iready", i_ready, 1'b1);
    check("mid_rst_outs", {ea, wb_en, flt_align, flt_bound, flt_canon, flt_mode}, '0);
    o_ready = 1'b1;
    idle(5);

    // Randomized traffic with random consumer stalls.
    rnd_ordy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      rand_req();
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rnd_ordy = 1'b0;
    o_ready = 1'b1;
    idle(6);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
